// File: rtl/store_align_stage_pkg.sv
// Shared types and constants for the store-path formatter.
// Optional build macro STORE_SPLIT_EN enables two-beat word-crossing stores.
package store_align_stage_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    localparam logic [2:0] FUNCT3_STORE_SB = 3'b000;
    localparam logic [2:0] FUNCT3_STORE_SH = 3'b001;
    localparam logic [2:0] FUNCT3_STORE_SW = 3'b010;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } store_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10
    } store_state_e;

    // Unshifted byte-enable pattern for a store size; zero flags an illegal funct3.
    function automatic logic [3:0] size_strb(input logic [2:0] funct3);
        logic [3:0] strb;
        case (funct3)
            FUNCT3_STORE_SB: strb = 4'b0001;
            FUNCT3_STORE_SH: strb = 4'b0011;
            FUNCT3_STORE_SW: strb = 4'b1111;
            default:         strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/store_align_stage_if.sv
// Execute-side request and memory-side beat bus of the store formatter.
// master = environment (upstream + memory), slave = store_align_stage.
interface store_align_stage_if;
    import store_align_stage_pkg::*;

    logic              in_valid;
    logic              in_rdy;
    logic              in_store;
    logic [2:0]        in_funct3;
    logic [XLEN-1:0]   in_addr;
    logic [XLEN-1:0]   in_data;
    logic              mem_valid;
    logic              mem_rdy;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              fault;
    logic              busy;

    modport master (
        output in_valid, in_store, in_funct3, in_addr, in_data, mem_rdy,
        input  in_rdy, mem_valid, mem_addr, mem_wdata, mem_wstrb, fault, busy
    );

    modport slave (
        input  in_valid, in_store, in_funct3, in_addr, in_data, mem_rdy,
        output in_rdy, mem_valid, mem_addr, mem_wdata, mem_wstrb, fault, busy
    );

endinterface

// File: rtl/store_align_stage_lane_gen.sv
// Combinational lane generator: (addr, funct3, data) -> word-aligned beats.
// Beat 1 outputs exist only when STORE_SPLIT_EN is defined.
module store_lane_gen
    import store_align_stage_pkg::*;
(
    input  logic [XLEN-1:0] addr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data,
    output store_beat_t     beat0,
`ifdef STORE_SPLIT_EN
    output store_beat_t     beat1,
`endif
    output logic            has_beat1,
    output logic            illegal
);

    logic [3:0]      size_m_s;
    logic [1:0]      off_s;
    logic [7:0]      lane_m_s;
    logic [4:0]      shamt_s;
    logic [XLEN-1:0] data_m_s;
    logic [XLEN-1:0] base_s;

    // Mask rs2 to the store size, then shift bytes and strobes into their lanes.
    always_comb begin
        size_m_s  = size_strb(funct3);
        illegal   = (size_m_s == 4'b0000);
        off_s     = addr[1:0];
        shamt_s   = {off_s, 3'b000};
        lane_m_s  = {4'b0000, size_m_s} << off_s;
        data_m_s  = data & {{8{size_m_s[3]}}, {8{size_m_s[2]}},
                            {8{size_m_s[1]}}, {8{size_m_s[0]}}};
        base_s    = {addr[XLEN-1:2], 2'b00};
        has_beat1 = |lane_m_s[7:4];

        beat0.addr  = base_s;
        beat0.wstrb = lane_m_s[3:0];
        beat0.wdata = data_m_s << shamt_s;
`ifdef STORE_SPLIT_EN
        // Upper half of the 64-bit shifted value; the address wraps at 2^32.
        beat1.addr  = base_s + 32'd4;
        beat1.wstrb = lane_m_s[7:4];
        if (off_s == 2'b00) begin
            beat1.wdata = 32'h0000_0000;
        end else begin
            beat1.wdata = data_m_s >> (6'd32 - {1'b0, shamt_s});
        end
`endif
    end

endmodule

// File: rtl/store_align_stage.sv
// Store-path formatter: accepts one store per handshake and emits registered
// memory beats. Build macro STORE_SPLIT_EN enables two-beat word-crossing stores.
module store_align_stage
    import store_align_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    store_align_stage_if.slave  bus
);

    store_beat_t  beat0_s;
    logic         has_beat1_s;
    logic         illegal_s;
    logic         in_rdy_s;
    logic         accept_s;
    logic         start_s;
    logic         fault_s;

    store_state_e state_r;
    store_beat_t  out_r;
    logic         mem_valid_r;
    logic         fault_r;
`ifdef STORE_SPLIT_EN
    store_beat_t  beat1_s;
    store_beat_t  beat1_r;
    logic         pend1_r;
`endif

    store_lane_gen u_lane_gen (
        .addr      (bus.in_addr),
        .funct3    (bus.in_funct3),
        .data      (bus.in_data),
        .beat0     (beat0_s),
`ifdef STORE_SPLIT_EN
        .beat1     (beat1_s),
`endif
        .has_beat1 (has_beat1_s),
        .illegal   (illegal_s)
    );

    // Ready depends only on state and mem_rdy so it never loops back through in_valid.
    always_comb begin
        in_rdy_s = 1'b0;
        case (state_r)
            ST_IDLE:  in_rdy_s = 1'b1;
`ifdef STORE_SPLIT_EN
            ST_BEAT0: in_rdy_s = !pend1_r && bus.mem_rdy;
            ST_BEAT1: in_rdy_s = bus.mem_rdy;
`else
            ST_BEAT0: in_rdy_s = bus.mem_rdy;
`endif
            default:  in_rdy_s = 1'b0;
        endcase

        accept_s = bus.in_valid && in_rdy_s;
`ifdef STORE_SPLIT_EN
        start_s  = accept_s && bus.in_store && !illegal_s;
        fault_s  = accept_s && bus.in_store && illegal_s;
`else
        start_s  = accept_s && bus.in_store && !illegal_s && !has_beat1_s;
        fault_s  = accept_s && bus.in_store && (illegal_s || has_beat1_s);
`endif
    end

    // Beat FSM with registered payload; a free slot (in_rdy) either loads a new store or idles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_r       <= '0;
            mem_valid_r <= 1'b0;
            fault_r     <= 1'b0;
`ifdef STORE_SPLIT_EN
            beat1_r     <= '0;
            pend1_r     <= 1'b0;
`endif
        end else begin
            fault_r <= fault_s;
            if (in_rdy_s) begin
                if (start_s) begin
                    state_r     <= ST_BEAT0;
                    out_r       <= beat0_s;
                    mem_valid_r <= 1'b1;
`ifdef STORE_SPLIT_EN
                    beat1_r     <= beat1_s;
                    pend1_r     <= has_beat1_s;
`endif
                end else begin
                    state_r     <= ST_IDLE;
                    out_r       <= '0;
                    mem_valid_r <= 1'b0;
`ifdef STORE_SPLIT_EN
                    pend1_r     <= 1'b0;
`endif
                end
            end else begin
                case (state_r)
                    ST_BEAT0: begin
`ifdef STORE_SPLIT_EN
                        if (bus.mem_rdy) begin
                            state_r <= ST_BEAT1;
                            out_r   <= beat1_r;
                            pend1_r <= 1'b0;
                        end else begin
                            state_r <= ST_BEAT0;
                        end
`else
                        state_r <= ST_BEAT0;
`endif
                    end
                    default: state_r <= state_r;
                endcase
            end
        end
    end

    assign bus.in_rdy    = in_rdy_s;
    assign bus.mem_valid = mem_valid_r;
    assign bus.mem_addr  = out_r.addr;
    assign bus.mem_wdata = out_r.wdata;
    assign bus.mem_wstrb = out_r.wstrb;
    assign bus.fault     = fault_r;
    assign bus.busy      = mem_valid_r;

endmodule

// File: tb/tb_store_align_stage.sv
// Self-checking bench for store_align_stage: vector table plus hand-written
// sequences; expected beats go through a scoreboard queue.
module tb_store_align_stage;
    import store_align_stage_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_align_stage_if bus ();

    store_align_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        int          nb;
        logic [31:0] a0;
        logic [3:0]  s0;
        logic [31:0] w0;
        logic [31:0] a1;
        logic [3:0]  s1;
        logic [31:0] w1;
        logic        flt;
    } vec_t;

    vec_t        vecs [13];
    store_beat_t exp_q [$];
    int          checks    = 0;
    int          errors    = 0;
    int          fault_cnt = 0;
    int          beat_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
        store_beat_t b;
        b.addr  = a;
        b.wstrb = s;
        b.wdata = w;
        exp_q.push_back(b);
    endtask

    // Call just after a rising edge; returns after the falling edge where in_rdy was seen high.
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int waits);
        bit ok;
        bus.in_valid  = 1'b1;
        bus.in_store  = st;
        bus.in_funct3 = f3;
        bus.in_addr   = a;
        bus.in_data   = d;
        waits = 0;
        ok    = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_rdy) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept timeout: in_rdy low for %0d cycles, expected high", waits);
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0 && !bus.mem_valid) break;
            @(negedge clk);
        end
        chk({name, " pending beats"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int          w;
        int          f0;
        int          b0;
        int          nb_e;
        logic        flt_e;
        logic [31:0] addr_b;
        logic [31:0] a0_b;
        logic [3:0]  s0_b;
        logic [31:0] w0_b;

        vecs[0]  = '{1'b1, FUNCT3_STORE_SW, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0, 4'h0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, FUNCT3_STORE_SB, 32'h0000_0203, 32'h0000_00A5, 1, 32'h0000_0200, 4'h8, 32'hA500_0000, 32'h0, 4'h0, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, FUNCT3_STORE_SH, 32'h0000_0303, 32'h0000_1234, 2, 32'h0000_0300, 4'h8, 32'h3400_0000, 32'h0000_0304, 4'h1, 32'h0000_0012, 1'b0};
        vecs[3]  = '{1'b1, FUNCT3_STORE_SH, 32'h0000_0102, 32'hFFFF_ABCD, 1, 32'h0000_0100, 4'hC, 32'hABCD_0000, 32'h0, 4'h0, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, FUNCT3_STORE_SB, 32'h0000_0401, 32'h1234_5678, 1, 32'h0000_0400, 4'h2, 32'h0000_7800, 32'h0, 4'h0, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, FUNCT3_STORE_SW, 32'h0000_0401, 32'hAABB_CCDD, 2, 32'h0000_0400, 4'hE, 32'hBBCC_DD00, 32'h0000_0404, 4'h1, 32'h0000_00AA, 1'b0};
        vecs[6]  = '{1'b1, FUNCT3_STORE_SW, 32'hFFFF_FFFE, 32'h1122_3344, 2, 32'hFFFF_FFFC, 4'hC, 32'h3344_0000, 32'h0000_0000, 4'h3, 32'h0000_1122, 1'b0};
        vecs[7]  = '{1'b1, 3'b011,          32'h0000_0500, 32'h5555_5555, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, FUNCT3_STORE_SW, 32'h0000_0600, 32'h6666_6666, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
        vecs[9]  = '{1'b1, FUNCT3_STORE_SH, 32'h0000_0005, 32'h0000_BEEF, 1, 32'h0000_0004, 4'h6, 32'h00BE_EF00, 32'h0, 4'h0, 32'h0, 1'b0};
        vecs[10] = '{1'b1, 3'b100,          32'h0000_0700, 32'h7777_7777, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b1, FUNCT3_STORE_SB, 32'h0000_0000, 32'hFFFF_FF5A, 1, 32'h0000_0000, 4'h1, 32'h0000_005A, 32'h0, 4'h0, 32'h0, 1'b0};
        vecs[12] = '{1'b0, 3'b111,          32'h0000_0803, 32'h8888_8888, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_store  = 1'b0;
        bus.in_funct3 = 3'b000;
        bus.in_addr   = 32'h0;
        bus.in_data   = 32'h0;
        bus.mem_rdy   = 1'b1;

        // Monitor: scoreboard pop on every completed beat, fault pulse count, busy tracking.
        fork
            forever begin
                store_beat_t b;
                @(negedge clk);
                if (rst_n) begin
                    if (bus.fault) fault_cnt++;
                    chk("busy vs mem_valid", {31'd0, bus.busy}, {31'd0, bus.mem_valid});
                    if (bus.mem_valid && bus.mem_rdy) begin
                        beat_cnt++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected beat: got addr %h wstrb %h wdata %h, expected none",
                                     bus.mem_addr, bus.mem_wstrb, bus.mem_wdata);
                        end else begin
                            b = exp_q.pop_front();
                            chk("beat addr",  bus.mem_addr,  b.addr);
                            chk("beat wstrb", {28'd0, bus.mem_wstrb}, {28'd0, b.wstrb});
                            chk("beat wdata", bus.mem_wdata, b.wdata);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("rst mem_addr",  bus.mem_addr,  32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        chk("rst fault",     {31'd0, bus.fault}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst in_rdy", {31'd0, bus.in_rdy}, 32'd1);

        // Vector table with mem_rdy held high
        for (int i = 0; i < 13; i++) begin
            nb_e  = vecs[i].nb;
            flt_e = vecs[i].flt;
`ifndef STORE_SPLIT_EN
            if (vecs[i].nb == 2) begin
                nb_e  = 0;
                flt_e = 1'b1;
            end
`endif
            f0 = fault_cnt;
            b0 = beat_cnt;
            @(posedge clk); #1;
            send(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].data, w);
            if (nb_e >= 1) push_beat(vecs[i].a0, vecs[i].s0, vecs[i].w0);
            if (nb_e == 2) push_beat(vecs[i].a1, vecs[i].s1, vecs[i].w1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            repeat (4) @(negedge clk);
            chk($sformatf("v%0d fault pulses", i), fault_cnt - f0, {31'd0, flt_e});
            chk($sformatf("v%0d beats", i), beat_cnt - b0, nb_e);
            drain($sformatf("v%0d", i));
        end

        // Word-crossing sh: latency, in_rdy low during beat 0 (or fault when split is off)
        @(posedge clk); #1;
        send(1'b1, FUNCT3_STORE_SH, 32'h0000_0303, 32'h0000_1234, w);
`ifdef STORE_SPLIT_EN
        push_beat(32'h0000_0300, 4'h8, 32'h3400_0000);
        push_beat(32'h0000_0304, 4'h1, 32'h0000_0012);
`endif
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
`ifdef STORE_SPLIT_EN
        chk("split b0 valid",  {31'd0, bus.mem_valid}, 32'd1);
        chk("split b0 addr",   bus.mem_addr, 32'h0000_0300);
        chk("split b0 in_rdy", {31'd0, bus.in_rdy}, 32'd0);
        @(negedge clk);
        chk("split b1 addr",   bus.mem_addr, 32'h0000_0304);
        chk("split b1 in_rdy", {31'd0, bus.in_rdy}, 32'd1);
`else
        chk("nosplit valid",   {31'd0, bus.mem_valid}, 32'd0);
        chk("nosplit fault",   {31'd0, bus.fault}, 32'd1);
        @(negedge clk);
        chk("nosplit fault end", {31'd0, bus.fault}, 32'd0);
        chk("nosplit in_rdy",  {31'd0, bus.in_rdy}, 32'd1);
`endif
        drain("split seq");

        // Stall with mem_rdy low, then reset during beat 0
`ifdef STORE_SPLIT_EN
        addr_b = 32'h0000_0401; s0_b = 4'hE; w0_b = 32'hBBCC_DD00;
`else
        addr_b = 32'h0000_0400; s0_b = 4'hF; w0_b = 32'hAABB_CCDD;
`endif
        a0_b = 32'h0000_0400;
        bus.mem_rdy = 1'b0;
        @(posedge clk); #1;
        send(1'b1, FUNCT3_STORE_SW, addr_b, 32'hAABB_CCDD, w);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d valid", k), {31'd0, bus.mem_valid}, 32'd1);
            chk($sformatf("stall%0d addr", k),  bus.mem_addr, a0_b);
            chk($sformatf("stall%0d wstrb", k), {28'd0, bus.mem_wstrb}, {28'd0, s0_b});
            chk($sformatf("stall%0d wdata", k), bus.mem_wdata, w0_b);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("async rst addr",  bus.mem_addr,  32'd0);
        chk("async rst wdata", bus.mem_wdata, 32'd0);
        chk("async rst wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        chk("async rst busy",  {31'd0, bus.busy}, 32'd0);
        chk("async rst fault", {31'd0, bus.fault}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_rdy = 1'b1;
        b0 = beat_cnt;
        repeat (5) @(negedge clk);
        chk("post-rst no beat", beat_cnt - b0, 32'd0);
        chk("post-rst ready",   {31'd0, bus.in_rdy}, 32'd1);

        // Back-to-back aligned words: one beat per cycle, no bubbles
        b0 = beat_cnt;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, FUNCT3_STORE_SW, 32'h0000_0500 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), w);
            push_beat(32'h0000_0500 + 32'(i * 4), 4'hF, 32'hC0DE_0000 + 32'(i));
            chk($sformatf("b2b%0d waits", i), w, 32'd0);
            if (i > 0) chk($sformatf("b2b%0d valid", i), {31'd0, bus.mem_valid}, 32'd1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b last valid", {31'd0, bus.mem_valid}, 32'd1);
        @(negedge clk);
        chk("b2b idle", {31'd0, bus.mem_valid}, 32'd0);
        chk("b2b beats", beat_cnt - b0, 32'd4);
        drain("b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
